riscv_seq_divider: RTL and testbench

//  Iterative radix-2 restoring divider: the division counterpart of the pipelined

---
 rtl/riscv_pe_div_pkg.sv | 18 +
 rtl/riscv_seq_divider_div_step.sv | 31 +++
 rtl/riscv_seq_divider.sv | 135 +++++++++++++
 tb/tb_riscv_seq_divider.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pe_div_pkg.sv
// Shared definitions for the PE M-extension divider: op encoding, FSM states, default width.
package riscv_pe_div_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/riscv_seq_divider_div_step.sv
// One restoring-division iteration: shift {r,q} left, subtract divisor, keep if non-negative.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] r_in,
  input  logic [XLEN-1:0] q_in,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] r_out,
  output logic [XLEN-1:0] q_out
);

  logic [XLEN:0]          r_sh;
  logic signed [XLEN+1:0] trial;
  logic                   unused_trial_msb;

  always_comb begin
    r_sh  = {r_in, q_in[XLEN-1]};
    trial = $signed({1'b0, r_sh}) - $signed({2'b00, d});
    if (trial >= 0) begin
      r_out = trial[XLEN-1:0];
      q_out = {q_in[XLEN-2:0], 1'b1};
    end else begin
      r_out = r_sh[XLEN-1:0];
      q_out = {q_in[XLEN-2:0], 1'b0};
    end
  end

  // A kept trial is always below d, so bit XLEN is zero whenever it is used.
  assign unused_trial_msb = trial[XLEN];

endmodule

// File: rtl/riscv_seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with RISC-V corner-case semantics.
module riscv_seq_divider
  import riscv_pe_div_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  div_state_e       state, state_d;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  r_q, q_q, d_q, a_q;
  logic             neg_q_q, neg_r_q, dz_q, ovf_q, rem_sel_q;
  logic [XLEN-1:0]  r_nxt, q_nxt;

  logic            accept, is_signed_in, sa_in, sb_in, dz_in, ovf_in, special_in;
  logic [XLEN-1:0] early_q, early_r, fix_q, fix_r;

  assign in_ready     = (state == IDLE);
  assign accept       = in_valid && (state == IDLE) && !flush;
  assign is_signed_in = ~op[0];
  assign sa_in        = is_signed_in & A[XLEN-1];
  assign sb_in        = is_signed_in & B[XLEN-1];
  assign dz_in        = (B == '0);
  assign ovf_in       = is_signed_in && (A == MIN_NEG) && (B == '1);
  assign special_in   = dz_in || ovf_in;

  assign early_q = dz_in ? '1 : MIN_NEG;
  assign early_r = dz_in ? A  : '0;

  // Corner cases override whatever the iterations produced on the magnitudes.
  assign fix_q = dz_q ? '1  : (ovf_q ? MIN_NEG : cond_neg(q_q, neg_q_q));
  assign fix_r = dz_q ? a_q : (ovf_q ? '0      : cond_neg(r_q, neg_r_q));

  div_step #(.XLEN(XLEN)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .d     (d_q),
    .r_out (r_nxt),
    .q_out (q_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) state_d = (EARLY_OUT && special_in) ? DONE : CALC;
      CALC: if (count == CNT_LAST) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_valid && out_ready) state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Control and architectural outputs: reset and flush apply here.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      out_valid <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      result    <= '0;
    end else if (flush) begin
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count <= '0;
            if (EARLY_OUT && special_in) begin
              quot   <= early_q;
              rem    <= early_r;
              result <= op[1] ? early_r : early_q;
            end
          end
        end
        CALC: count <= count + 1'b1;
        FIX: begin
          quot   <= fix_q;
          rem    <= fix_r;
          result <= rem_sel_q ? fix_r : fix_q;
        end
        DONE: begin
          if (!out_valid)     out_valid <= 1'b1;
          else if (out_ready) out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Working datapath: operands captured once at accept, then iterated.
  always_ff @(posedge clk) begin
    if (accept) begin
      r_q       <= '0;
      q_q       <= cond_neg(A, sa_in);
      d_q       <= cond_neg(B, sb_in);
      a_q       <= A;
      neg_q_q   <= sa_in ^ sb_in;
      neg_r_q   <= sa_in;
      dz_q      <= dz_in;
      ovf_q     <= ovf_in;
      rem_sel_q <= op[1];
    end else if (state == CALC) begin
      r_q <= r_nxt;
      q_q <= q_nxt;
    end
  end

endmodule

// File: tb/tb_riscv_seq_divider.sv
// Directed-vector and corner-sequence bench for riscv_seq_divider.
`timescale 1ns/1ps
module tb_riscv_seq_divider;
  import riscv_pe_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result, quot, rem;

  int checks = 0;
  int errors = 0;

  riscv_seq_divider #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .quot(quot), .rem(rem)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b, q, r, res;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (o[0]) begin
      q = a / b;
      r = a % b;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] q, output logic [31:0] r,
                        output logic [31:0] res, output bit rdy_seen);
    int k;
    @(negedge clk);
    op = o; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 60) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    q = quot; r = rem; res = result;
    k = 0;
    while (!in_ready && k < 5) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  vec_t vecs [14];

  initial begin
    int          lat;
    logic [31:0] q, r, res, held, eq, er;
    bit          rdy_seen;
    int          bad;

    vecs[0]  = '{"divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         32'd2,          32'd14,         34};
    vecs[1]  = '{"div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  32'hFFFF_FFFD,  34};
    vecs[2]  = '{"rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  34};
    vecs[3]  = '{"div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'h8000_0000,  1};
    vecs[4]  = '{"rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'd0,          1};
    vecs[5]  = '{"remu_5_0",     OP_REMU, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          32'd5,          1};
    vecs[6]  = '{"div_5_0",      OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          32'hFFFF_FFFF,  1};
    vecs[7]  = '{"rem_m5_0",     OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  32'hFFFF_FFFB,  1};
    vecs[8]  = '{"divu_min_m1",  OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  32'd0,          34};
    vecs[9]  = '{"divu_max_1",   OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  34};
    vecs[10] = '{"div_50_m5",    OP_DIV,  32'd50,         32'hFFFF_FFFB,  32'hFFFF_FFF6,  32'd0,          32'hFFFF_FFF6,  34};
    vecs[11] = '{"rem_7_m2",     OP_REM,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          32'd1,          34};
    vecs[12] = '{"div_m8_m3",    OP_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE,  32'd2,          34};
    vecs[13] = '{"remu_0_3",     OP_REMU, 32'd0,          32'd3,          32'd0,          32'd0,          32'd0,          34};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_quot", quot, 32'd0);
    chk("reset_rem", rem, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, q, r, res, rdy_seen);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      chk({vecs[i].name, "_quot"}, q, vecs[i].q);
      chk({vecs[i].name, "_rem"}, r, vecs[i].r);
      chk({vecs[i].name, "_result"}, res, vecs[i].res);
      chk({vecs[i].name, "_busy"}, {31'd0, rdy_seen}, 32'd0);
    end

    // Backpressure: result held, divider stays busy until the consumer takes it.
    out_ready = 1'b0;
    run_op(OP_DIVU, 32'd1000, 32'd10, lat, q, r, res, rdy_seen);
    chk("bp_lat", 32'(lat), 32'd34);
    chk("bp_result", res, 32'd100);
    held = result;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    chk("bp_stable", 32'(bad), 32'd0);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd0);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, lat, q, r, res, rdy_seen);
    chk("bp2_quot", q, 32'hFFFF_FFFF);
    chk("bp2_rem", r, 32'd0);

    // Flush mid-CALC (count 10), with a competing request on the flush cycle.
    @(negedge clk);
    op = OP_DIV; A = 32'd100; B = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; op = OP_DIVU; A = 32'd9; B = 32'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_no_accept", {31'd0, in_ready}, 32'd1);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    chk("flush_quiet", 32'(bad), 32'd0);
    run_op(OP_DIV, 32'd50, 32'hFFFF_FFFB, lat, q, r, res, rdy_seen);
    chk("post_flush_lat", 32'(lat), 32'd34);
    chk("post_flush_quot", q, 32'hFFFF_FFF6);
    chk("post_flush_rem", r, 32'd0);

    // Reset while calculating.
    @(negedge clk);
    op = OP_DIVU; A = 32'd77; B = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_calc_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_calc_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_calc_quot", quot, 32'd0);
    chk("rst_calc_rem", rem, 32'd0);
    chk("rst_calc_result", result, 32'd0);

    // Reset while holding a finished result.
    out_ready = 1'b0;
    run_op(OP_DIVU, 32'd77, 32'd5, lat, q, r, res, rdy_seen);
    chk("pre_rst_done_quot", q, 32'd15);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rst_done_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_done_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done_quot", quot, 32'd0);
    chk("rst_done_rem", rem, 32'd0);
    chk("rst_done_result", result, 32'd0);

    // Randomised ops against the reference model, with corner operands mixed in.
    for (int n = 0; n < 300; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int          elat;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = rb >> $urandom_range(1, 31);
        3: ra = ra >> $urandom_range(1, 31);
        default: ;
      endcase
      model(ro, ra, rb, eq, er);
      elat = ((rb == 32'd0) || (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 34;
      run_op(ro, ra, rb, lat, q, r, res, rdy_seen);
      chk($sformatf("rnd%0d_quot", n), q, eq);
      chk($sformatf("rnd%0d_rem", n), r, er);
      chk($sformatf("rnd%0d_result", n), res, ro[1] ? er : eq);
      chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(elat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
